// File: rtl/ulpi_pkg.sv
// ULPI PHY responder shared definitions.
// FSM state codes, TX CMD codes, register map, reset values.
`timescale 1ns/1ps
package ulpi_pkg;

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_WR_ACK   = 4'd1;
  localparam logic [3:0] S_WR_DATA  = 4'd2;
  localparam logic [3:0] S_WR_STP   = 4'd3;
  localparam logic [3:0] S_RD_ACK   = 4'd4;
  localparam logic [3:0] S_RD_TURN1 = 4'd5;
  localparam logic [3:0] S_RD_DATA  = 4'd6;
  localparam logic [3:0] S_RD_TURN2 = 4'd7;
  localparam logic [3:0] S_TX       = 4'd8;
  localparam logic [3:0] S_RX_TURN1 = 4'd9;
  localparam logic [3:0] S_RX_CMD   = 4'd10;
  localparam logic [3:0] S_RX_TURN2 = 4'd11;

  localparam logic [1:0] CMD_NOOP = 2'b00;
  localparam logic [1:0] CMD_TX   = 2'b01;
  localparam logic [1:0] CMD_WR   = 2'b10;
  localparam logic [1:0] CMD_RD   = 2'b11;

  localparam logic [5:0] A_VID_LO = 6'h00;
  localparam logic [5:0] A_VID_HI = 6'h01;
  localparam logic [5:0] A_PID_LO = 6'h02;
  localparam logic [5:0] A_PID_HI = 6'h03;
  localparam logic [5:0] A_FUNC   = 6'h04;
  localparam logic [5:0] A_FUNC_S = 6'h05;
  localparam logic [5:0] A_FUNC_C = 6'h06;
  localparam logic [5:0] A_IFC    = 6'h07;
  localparam logic [5:0] A_IFC_S  = 6'h08;
  localparam logic [5:0] A_IFC_C  = 6'h09;
  localparam logic [5:0] A_OTG    = 6'h0A;
  localparam logic [5:0] A_OTG_S  = 6'h0B;
  localparam logic [5:0] A_OTG_C  = 6'h0C;
  localparam logic [5:0] A_SCR    = 6'h16;
  localparam logic [5:0] A_SCR_S  = 6'h17;
  localparam logic [5:0] A_SCR_C  = 6'h18;

  localparam logic [7:0] FUNC_RST = 8'h41;
  localparam logic [7:0] IFC_RST  = 8'h00;
  localparam logic [7:0] OTG_RST  = 8'h06;
  localparam logic [7:0] FUNC_RESET_BIT = 8'h20;

endpackage

// File: rtl/ulpi_phy_responder_if.sv
// ULPI bus bundle between a link (master) and a PHY (slave).
// Signal names are from the PHY point of view.
`timescale 1ns/1ps
interface ulpi_phy_responder_if;
  logic [7:0] data_i;
  logic [7:0] data_o;
  logic [7:0] data_t;
  logic       stp;
  logic       dir;
  logic       nxt;

  modport master (
    output data_i, stp,
    input  data_o, data_t, dir, nxt
  );

  modport slave (
    input  data_i, stp,
    output data_o, data_t, dir, nxt
  );
endinterface

// File: rtl/ulpi_phy_regfile.sv
// ULPI PHY register file: set/clear triplets, ID bytes,
// and the self-clearing Reset bit of Function Control.
`timescale 1ns/1ps
module ulpi_phy_regfile
  import ulpi_pkg::*;
#(
  parameter logic [15:0] VENDOR_ID   = 16'h0424,
  parameter logic [15:0] PRODUCT_ID  = 16'h0009,
  parameter logic [7:0]  SCRATCH_RST = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       we_i,
  input  logic [5:0] addr_i,
  input  logic [7:0] wdata_i,
  output logic [7:0] rdata_o,
  output logic [7:0] func_o,
  output logic [7:0] ifc_o,
  output logic [7:0] otg_o
);

  logic [7:0] func_q, func_d;
  logic [7:0] ifc_q, ifc_d;
  logic [7:0] otg_q, otg_d;
  logic [7:0] scr_q, scr_d;

  // commit one write/set/clear; Reset bit drops the cycle after
  always_comb begin
    func_d = func_q & ~FUNC_RESET_BIT;
    ifc_d  = ifc_q;
    otg_d  = otg_q;
    scr_d  = scr_q;
    if (we_i) begin
      case (addr_i)
        A_FUNC:   func_d = wdata_i;
        A_FUNC_S: func_d = func_q | wdata_i;
        A_FUNC_C: func_d = func_q & ~wdata_i;
        A_IFC:    ifc_d  = wdata_i;
        A_IFC_S:  ifc_d  = ifc_q | wdata_i;
        A_IFC_C:  ifc_d  = ifc_q & ~wdata_i;
        A_OTG:    otg_d  = wdata_i;
        A_OTG_S:  otg_d  = otg_q | wdata_i;
        A_OTG_C:  otg_d  = otg_q & ~wdata_i;
        A_SCR:    scr_d  = wdata_i;
        A_SCR_S:  scr_d  = scr_q | wdata_i;
        A_SCR_C:  scr_d  = scr_q & ~wdata_i;
        default:  ;
      endcase
    end
  end

  // read mux; aliases return the base register
  always_comb begin
    case (addr_i)
      A_VID_LO: rdata_o = VENDOR_ID[7:0];
      A_VID_HI: rdata_o = VENDOR_ID[15:8];
      A_PID_LO: rdata_o = PRODUCT_ID[7:0];
      A_PID_HI: rdata_o = PRODUCT_ID[15:8];
      A_FUNC, A_FUNC_S, A_FUNC_C: rdata_o = func_q;
      A_IFC, A_IFC_S, A_IFC_C:    rdata_o = ifc_q;
      A_OTG, A_OTG_S, A_OTG_C:    rdata_o = otg_q;
      A_SCR, A_SCR_S, A_SCR_C:    rdata_o = scr_q;
      default:  rdata_o = 8'h00;
    endcase
  end

  // register state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      func_q <= FUNC_RST;
      ifc_q  <= IFC_RST;
      otg_q  <= OTG_RST;
      scr_q  <= SCRATCH_RST;
    end else begin
      func_q <= func_d;
      ifc_q  <= ifc_d;
      otg_q  <= otg_d;
      scr_q  <= scr_d;
    end
  end

  assign func_o = func_q;
  assign ifc_o  = ifc_q;
  assign otg_o  = otg_q;

endmodule

// File: rtl/ulpi_phy_responder.sv
// ULPI PHY-side responder: register access, TX packets,
// optional RX CMDs when ULPI_RXCMD_EN is defined.
`timescale 1ns/1ps
module ulpi_phy_responder
  import ulpi_pkg::*;
#(
  parameter logic [15:0] VENDOR_ID   = 16'h0424,
  parameter logic [15:0] PRODUCT_ID  = 16'h0009,
  parameter logic [7:0]  SCRATCH_RST = 8'h00
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic [7:0]  ULPI_data_i,
  output logic [7:0]  ULPI_data_o,
  output logic [7:0]  ULPI_data_t,
  input  logic        ULPI_stp,
  output logic        ULPI_dir,
  output logic        ULPI_nxt,
  input  logic [1:0]  linestate,
  output logic [7:0]  func_ctrl,
  output logic [7:0]  if_ctrl,
  output logic [7:0]  otg_ctrl,
  output logic [15:0] tx_pkt_cnt,
  output logic [15:0] tx_last_len
);

  logic [3:0]  state_q, state_d;
  logic [5:0]  addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [15:0] pkt_q, pkt_d;
  logic [15:0] last_q, last_d;
  logic [15:0] len_q, len_d;
  logic        first_q, first_d;
  logic        dir_q, dir_d;
  logic        nxt_q, nxt_d;
  logic [7:0]  dout_q, dout_d;
  logic [7:0]  dt_q, dt_d;
  logic        we;
  logic [7:0]  rdata;
`ifdef ULPI_RXCMD_EN
  logic [1:0]  ls_q, ls_d;
`else
  logic        unused_ls;
  assign unused_ls = ^linestate;
`endif

  ulpi_phy_regfile #(
    .VENDOR_ID   (VENDOR_ID),
    .PRODUCT_ID  (PRODUCT_ID),
    .SCRATCH_RST (SCRATCH_RST)
  ) u_regs (
    .clk     (aclk),
    .rst_n   (aresetn),
    .we_i    (we),
    .addr_i  (addr_q),
    .wdata_i (wdata_q),
    .rdata_o (rdata),
    .func_o  (func_ctrl),
    .ifc_o   (if_ctrl),
    .otg_o   (otg_ctrl)
  );

  // transaction FSM and packet accounting
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    pkt_d   = pkt_q;
    last_d  = last_q;
    len_d   = len_q;
    first_d = 1'b0;
    we      = 1'b0;
`ifdef ULPI_RXCMD_EN
    ls_d    = ls_q;
`endif
    case (state_q)
      S_IDLE: begin
        case (ULPI_data_i[7:6])
          CMD_TX: begin
            state_d = S_TX;
            first_d = 1'b1;
            len_d   = 16'h0000;
          end
          CMD_WR: begin
            state_d = S_WR_ACK;
            addr_d  = ULPI_data_i[5:0];
          end
          CMD_RD: begin
            state_d = S_RD_ACK;
            addr_d  = ULPI_data_i[5:0];
          end
          default: begin
`ifdef ULPI_RXCMD_EN
            if (linestate != ls_q)
              state_d = S_RX_TURN1;
`endif
          end
        endcase
      end
      S_WR_ACK:   state_d = S_WR_DATA;
      S_WR_DATA: begin
        if (ULPI_stp) begin
          state_d = S_IDLE;
        end else begin
          wdata_d = ULPI_data_i;
          state_d = S_WR_STP;
        end
      end
      S_WR_STP: begin
        if (ULPI_stp) begin
          we      = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_RD_ACK:   state_d = S_RD_TURN1;
      S_RD_TURN1: state_d = S_RD_DATA;
      S_RD_DATA:  state_d = S_RD_TURN2;
      S_RD_TURN2: state_d = S_IDLE;
      S_TX: begin
        if (ULPI_stp) begin
          pkt_d   = pkt_q + 16'd1;
          last_d  = len_q;
          state_d = S_IDLE;
        end else if (!first_q && len_q != 16'hFFFF) begin
          len_d = len_q + 16'd1;
        end
      end
`ifdef ULPI_RXCMD_EN
      S_RX_TURN1: state_d = S_RX_CMD;
      S_RX_CMD: begin
        ls_d    = dout_q[1:0];
        state_d = S_RX_TURN2;
      end
      S_RX_TURN2: state_d = S_IDLE;
`endif
      default:    state_d = S_IDLE;
    endcase
  end

  // bus outputs follow the next state so they come out registered
  always_comb begin
    nxt_d = (state_d == S_WR_ACK) || (state_d == S_WR_DATA) ||
            (state_d == S_RD_ACK) || (state_d == S_TX);
    dir_d = (state_d == S_RD_TURN1) || (state_d == S_RD_DATA) ||
            (state_d == S_RX_TURN1) || (state_d == S_RX_CMD);
    dt_d  = 8'hFF;
    dout_d = 8'h00;
    if (state_d == S_RD_DATA) begin
      dt_d   = 8'h00;
      dout_d = rdata;
    end else if (state_d == S_RX_CMD) begin
      dt_d   = 8'h00;
      dout_d = {6'b000000, linestate};
    end
  end

  // state and output registers
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= S_IDLE;
      addr_q  <= 6'h00;
      wdata_q <= 8'h00;
      pkt_q   <= 16'h0000;
      last_q  <= 16'h0000;
      len_q   <= 16'h0000;
      first_q <= 1'b0;
      dir_q   <= 1'b0;
      nxt_q   <= 1'b0;
      dout_q  <= 8'h00;
      dt_q    <= 8'hFF;
`ifdef ULPI_RXCMD_EN
      ls_q    <= 2'b01;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      pkt_q   <= pkt_d;
      last_q  <= last_d;
      len_q   <= len_d;
      first_q <= first_d;
      dir_q   <= dir_d;
      nxt_q   <= nxt_d;
      dout_q  <= dout_d;
      dt_q    <= dt_d;
`ifdef ULPI_RXCMD_EN
      ls_q    <= ls_d;
`endif
    end
  end

  assign ULPI_dir    = dir_q;
  assign ULPI_nxt    = nxt_q;
  assign ULPI_data_o = dout_q;
  assign ULPI_data_t = dt_q;
  assign tx_pkt_cnt  = pkt_q;
  assign tx_last_len = last_q;

endmodule
